// File: rtl/rle_pixel_decoder_pkg.sv
// rle_pixel_decoder_pkg: instruction field layout, EOF marker and decoder states
package rle_pixel_decoder_pkg;
    localparam int INSTR_W   = 20;
    localparam int COLOR_W   = 6;
    localparam int LEN_W     = 14;
    localparam int COLOR_LSB = 14;
    localparam int LEN_LSB   = 0;
    localparam logic [LEN_W-1:0] EOF_LEN = '0;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EOF_WAIT} state_t;

    function automatic logic [COLOR_W-1:0] instr_color(input logic [INSTR_W-1:0] w);
        return w[COLOR_LSB +: COLOR_W];
    endfunction

    function automatic logic [LEN_W-1:0] instr_len(input logic [INSTR_W-1:0] w);
        return w[LEN_LSB +: LEN_W];
    endfunction
endpackage

// File: rtl/rle_pixel_decoder_if.sv
// rle_pixel_decoder_if: instruction bus between flash reader (master) and decoder (slave)
// instr_in/instr_valid: instruction word and its one-cycle strobe; fetch_en: read enable back to the reader
interface rle_pixel_decoder_if;
    import rle_pixel_decoder_pkg::*;
    logic [INSTR_W-1:0] instr_in;
    logic               instr_valid;
    logic               fetch_en;
    modport master (output instr_in, output instr_valid, input fetch_en);
    modport slave  (input instr_in, input instr_valid, output fetch_en);
endinterface

// File: rtl/rle_pixel_decoder_fifo.sv
// rle_fifo: instruction buffer; push while full is dropped unless a pop happens the same cycle
// ports: clk, rst_n (sync, active-low), push/din, pop, head (combinational front word), count, full, empty
module rle_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rle_pixel_decoder.sv
// rle_pixel_decoder: run-length instruction decoder producing one RGB222 pixel per pixel slot
// ports: clk, rst_n (sync, active-low), ibus (instr_in/instr_valid in, fetch_en out), frame_start,
//        pixel_req, pixel_rgb (latency 1), eof_wait, clear_flags, sticky underrun/overflow/sync_err;
//        frame_pixels only when RLE_DEC_STATS_EN is defined
module rle_pixel_decoder
    import rle_pixel_decoder_pkg::*;
#(
    parameter int                 FIFO_DEPTH  = 4,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = 6'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    rle_pixel_decoder_if.slave ibus,
    input  logic               frame_start,
    input  logic               pixel_req,
    output logic [COLOR_W-1:0] pixel_rgb,
    output logic               eof_wait,
    input  logic               clear_flags,
    output logic               underrun,
    output logic               overflow,
    output logic               sync_err
`ifdef RLE_DEC_STATS_EN
    ,
    output logic [15:0]        frame_pixels
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_t             state, state_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic [COLOR_W-1:0] color, color_n, rgb_n;
    logic [INSTR_W-1:0] head;
    logic [CW-1:0]      fifo_count;
    logic               pop, full, empty, set_u, set_o, set_s;

    rle_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ibus.instr_valid),
        .pop   (pop),
        .din   (ibus.instr_in),
        .head  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign eof_wait = state == ST_EOF_WAIT;
    assign set_o    = ibus.instr_valid && full && !pop;

    // frame_start outside EOF_WAIT is a sync error and freezes state, count and the FIFO
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        color_n = color;
        pop     = 1'b0;
        rgb_n   = BLANK_COLOR;
        set_u   = 1'b0;
        set_s   = 1'b0;
        case (state)
            ST_IDLE: begin
                set_u = pixel_req;
                set_s = frame_start;
                if (!frame_start && !empty) begin
                    pop = 1'b1;
                    if (instr_len(head) == EOF_LEN) state_n = ST_EOF_WAIT;
                    else begin
                        state_n = ST_RUN;
                        cnt_n   = instr_len(head);
                        color_n = instr_color(head);
                    end
                end
            end
            ST_RUN: begin
                rgb_n = pixel_req ? color : BLANK_COLOR;
                set_s = frame_start;
                if (pixel_req && !frame_start) begin
                    cnt_n = cnt - LEN_W'(1);
                    // last pixel of the run: chain straight into the next word
                    if (cnt == LEN_W'(1)) begin
                        if (empty) state_n = ST_IDLE;
                        else begin
                            pop = 1'b1;
                            if (instr_len(head) == EOF_LEN) state_n = ST_EOF_WAIT;
                            else begin
                                cnt_n   = instr_len(head);
                                color_n = instr_color(head);
                            end
                        end
                    end
                end
            end
            ST_EOF_WAIT: state_n = frame_start ? ST_IDLE : ST_EOF_WAIT;
            default:     state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            color         <= BLANK_COLOR;
            pixel_rgb     <= BLANK_COLOR;
            ibus.fetch_en <= 1'b0;
            underrun      <= 1'b0;
            overflow      <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            color         <= color_n;
            pixel_rgb     <= rgb_n;
            ibus.fetch_en <= (fifo_count < CW'(FIFO_DEPTH-1)) && (state_n != ST_EOF_WAIT);
            underrun      <= set_u || (underrun && !clear_flags);
            overflow      <= set_o || (overflow && !clear_flags);
            sync_err      <= set_s || (sync_err && !clear_flags);
        end
    end

`ifdef RLE_DEC_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) frame_pixels <= '0;
        else if (pixel_req && state == ST_RUN && frame_pixels != 16'hFFFF) frame_pixels <= frame_pixels + 16'd1;
    end
`endif
endmodule

// File: doc/rle_pixel_decoder.md
RLE_PIXEL_DECODER -- requirements
Module: rle_pixel_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer depth; legal values 2, 4, 8 or 16.
REQ-002 SHALL have parameter BLANK_COLOR, default 6'h00, colour driven when no run is loaded.
REQ-003 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port instr_in, input, 20: instruction word from the flash reader.
REQ-006 SHALL have port instr_valid, input, 1: one-cycle strobe qualifying instr_in.
REQ-007 SHALL have port fetch_en, output, 1: drives the flash reader read_enable.
REQ-008 SHALL have port frame_start, input, 1: one-cycle pulse at the start of each frame.
REQ-009 SHALL have port pixel_req, input, 1: active-video pixel slot this cycle.
REQ-010 SHALL have port pixel_rgb, output, 6: RGB222 pixel colour.
REQ-011 SHALL have port eof_wait, output, 1: high while in EOF_WAIT.
REQ-012 SHALL have port clear_flags, input, 1: clears all sticky flags.
REQ-013 SHALL have ports underrun, overflow and sync_err, each output, 1: sticky error flags.

Function
REQ-014 Instruction format SHALL be: [19:14] colour (RGB222), [13:0] run length in pixels; run length 0 is the end-of-frame (EOF) marker.
REQ-015 instr_valid with instr_in SHALL push into the FIFO; a push while the FIFO is full and no pop occurs SHALL drop the word and set overflow.
REQ-016 A simultaneous push and pop SHALL both succeed, count unchanged, including when the FIFO is full.
REQ-017 fetch_en SHALL be registered and equal (fifo_count < FIFO_DEPTH-1), low in reset and in EOF_WAIT.
REQ-018 States SHALL be IDLE (no run loaded), RUN (run loaded, remaining count > 0) and EOF_WAIT.
REQ-019 IDLE SHALL pop the FIFO head when it is non-empty: length > 0 loads colour and count and goes to RUN; length 0 goes to EOF_WAIT.
REQ-020 In RUN, pixel_req SHALL emit the loaded colour and decrement count.
REQ-021 When count==1 and pixel_req are both present, the FIFO head SHALL be popped the same cycle if available, with no bubble: a non-zero head stays in RUN with the new run; an EOF head goes to EOF_WAIT; an empty FIFO goes to IDLE.
REQ-022 pixel_rgb SHALL be registered with latency 1 from pixel_req; cycles without pixel_req SHALL output BLANK_COLOR.
REQ-023 pixel_req in IDLE SHALL output BLANK_COLOR and set underrun.
REQ-024 pixel_req in EOF_WAIT SHALL output BLANK_COLOR without flagging.
REQ-025 frame_start in EOF_WAIT SHALL go to IDLE next cycle.
REQ-026 frame_start in IDLE or RUN SHALL set sync_err and SHALL NOT change state or count.
REQ-027 clear_flags SHALL clear all sticky flags; a set event in the same cycle SHALL win.

Reset
REQ-028 Reset SHALL produce: state IDLE, FIFO empty, count 0, pixel_rgb=BLANK_COLOR, fetch_en=0, all flags 0, eof_wait=0.
REQ-029 Reset mid-run SHALL discard buffered words and the current run; the first cycle after reset SHALL accept pushes.

Configuration
REQ-030 With RLE_DEC_STATS_EN defined, the block SHALL add output frame_pixels[15:0], counting pixels emitted with non-blank source (RUN) since the last frame_start, saturating at 16'hFFFF, cleared by frame_start and reset.
REQ-031 Without RLE_DEC_STATS_EN, the port and counter SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the instruction field positions/widths, the EOF length constant (0) and the state enumeration.
REQ-033 The FIFO SHALL be a sub-module rle_fifo, parameterised by depth and width, exposing push, pop, head, count, full and empty.

Verification
REQ-034 Push {6'h3F,14'd3}, {6'h05,14'd2}, then pixel_req held 5 cycles -> pixel_rgb 3F,3F,3F,05,05, no bubble, underrun=0.
REQ-035 Push {6'h12,14'd1}, then {EOF}, pixel_req 3 cycles -> 12, 00, 00; eof_wait=1 and fetch_en=0 until frame_start, then IDLE.
REQ-036 FIFO_DEPTH=4, five pushes without pops -> fetch_en falls after count reaches 3; the fifth push (FIFO full) is dropped and sets overflow; clear_flags clears it.
REQ-037 pixel_req with empty FIFO -> BLANK_COLOR and underrun=1; frame_start during RUN -> sync_err=1, run count unchanged.
REQ-038 rst_n low during a 100-pixel run -> next cycle all outputs at reset values, FIFO empty; a new push decodes normally.
REQ-039 With RLE_DEC_STATS_EN: run {6'h01,14'd640} fully emitted -> frame_pixels=640; frame_start -> 0.
